// File: rtl/superscalar_regfile.sv
// Multi-ported integer register file with per-register busy scoreboard for a multi-lane issue core.
// Define SUPERSCALAR_REGFILE_BYPASS_EN to forward same-cycle write data to read ports.
module superscalar_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int NRD  = 4,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NWR-1:0]      iss_en,
    input  logic [NWR*AW-1:0]   iss_addr,
    output logic                wr_conflict
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_wr_conflict;
    logic            w_conflict;

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NWR; i++) begin
            for (int j = i + 1; j < NWR; j++) begin
                if (wr_en[i] && wr_en[j] &&
                    (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]) &&
                    (wr_addr[i*AW +: AW] != '0)) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Ascending port loops: the highest-index (youngest) write wins, and issue sets land after write-back clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_busy        <= '0;
            r_wr_conflict <= 1'b0;
        end else begin
            r_wr_conflict <= w_conflict;
            for (int i = 0; i < NWR; i++) begin
                if (wr_en[i] && (wr_addr[i*AW +: AW] != '0)) begin
                    r_regs[wr_addr[i*AW +: AW]] <= wr_data[i*XLEN +: XLEN];
                    r_busy[wr_addr[i*AW +: AW]] <= 1'b0;
                end
            end
            for (int i = 0; i < NWR; i++) begin
                if (iss_en[i] && (iss_addr[i*AW +: AW] != '0)) begin
                    r_busy[iss_addr[i*AW +: AW]] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rd_addr[k*AW +: AW] != '0) begin
                rd_data[k*XLEN +: XLEN] = r_regs[rd_addr[k*AW +: AW]];
                rd_busy[k]              = r_busy[rd_addr[k*AW +: AW]];
`ifdef SUPERSCALAR_REGFILE_BYPASS_EN
                for (int i = 0; i < NWR; i++) begin
                    if (wr_en[i] && (wr_addr[i*AW +: AW] == rd_addr[k*AW +: AW])) begin
                        rd_data[k*XLEN +: XLEN] = wr_data[i*XLEN +: XLEN];
                        rd_busy[k]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_superscalar_regfile.sv
// Directed bench for superscalar_regfile at default parameters (XLEN=64, NREG=32, NRD=4, NWR=2).
module tb_superscalar_regfile;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      iss_en;
    logic [NWR*AW-1:0]   iss_addr;
    logic                wr_conflict;

    int n_vec = 0;
    int n_bad = 0;

    superscalar_regfile #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = '0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[p]               = 1'b1;
        wr_addr[p*AW +: AW]    = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_iss(input int p, input logic [AW-1:0] a);
        iss_en[p]            = 1'b1;
        iss_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [XLEN-1:0] rdat(input int k);
        return rd_data[k*XLEN +: XLEN];
    endfunction

    // Sets port 0 to address a, settles, checks data and busy.
    task automatic chk_reg(input string tag, input logic [AW-1:0] a,
                           input logic [XLEN-1:0] d, input logic b);
        set_rd(0, a);
        #1;
        chk({tag, "_data"}, rdat(0), d);
        chk({tag, "_busy"}, {63'd0, rd_busy[0]}, {63'd0, b});
    endtask

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        idle();
        tick();
        tick();

        // Reset state
        chk("rst_conflict", {63'd0, wr_conflict}, 64'd0);
        set_rd(0, 5'd1); set_rd(1, 5'd5); set_rd(2, 5'd9); set_rd(3, 5'd31);
        #1;
        chk("rst_data", {rdat(0) | rdat(1) | rdat(2) | rdat(3)}, 64'd0);
        chk("rst_busy", {60'd0, rd_busy}, 64'd0);
        rst_n = 1'b1;

        // x5 = 0x1234 on port 0
        set_wr(0, 5'd5, 64'h1234);
        tick();
        idle();
        set_rd(1, 5'd0);
        chk_reg("x5", 5'd5, 64'h1234, 1'b0);
        chk("x0_read", rdat(1), 64'd0);

        // Same-address double write: youngest port wins, conflict for one cycle
        set_wr(0, 5'd7, 64'hA);
        set_wr(1, 5'd7, 64'hB);
        tick();
        idle();
        chk("conf_set", {63'd0, wr_conflict}, 64'd1);
        chk_reg("x7", 5'd7, 64'hB, 1'b0);
        tick();
        chk("conf_clr", {63'd0, wr_conflict}, 64'd0);

        // Distinct-address double write: both land, no conflict
        set_wr(0, 5'd10, 64'hDEAD_BEEF_0000_0001);
        set_wr(1, 5'd11, 64'h0123_4567_89AB_CDEF);
        tick();
        idle();
        chk("conf_none", {63'd0, wr_conflict}, 64'd0);
        set_rd(1, 5'd11);
        chk_reg("x10", 5'd10, 64'hDEAD_BEEF_0000_0001, 1'b0);
        chk("x11", rdat(1), 64'h0123_4567_89AB_CDEF);

        // Issue to x9 then write-back clears busy
        set_iss(0, 5'd9);
        tick();
        idle();
        set_rd(1, 5'd10);
        chk_reg("x9_iss", 5'd9, 64'd0, 1'b1);
        chk("x10_notbusy", {63'd0, rd_busy[1]}, 64'd0);
        set_wr(1, 5'd9, 64'h55);
        tick();
        idle();
        chk_reg("x9_wb", 5'd9, 64'h55, 1'b0);

        // Same-cycle issue and write-back to x3: data updates, busy set wins
        set_iss(1, 5'd3);
        set_wr(0, 5'd3, 64'h33);
        tick();
        idle();
        chk_reg("x3_both", 5'd3, 64'h33, 1'b1);
        set_wr(0, 5'd3, 64'h34);
        tick();
        idle();
        chk_reg("x3_clr", 5'd3, 64'h34, 1'b0);

        // Two lanes issue to one register
        set_iss(0, 5'd12);
        set_iss(1, 5'd12);
        tick();
        idle();
        chk_reg("x12_dual", 5'd12, 64'd0, 1'b1);

        // x0 is never written and never busy; double write to x0 is not a conflict
        set_wr(0, 5'd0, 64'hFFFF);
        set_wr(1, 5'd0, 64'hFFFF);
        set_iss(0, 5'd0);
        set_iss(1, 5'd0);
        tick();
        idle();
        chk("x0_conf", {63'd0, wr_conflict}, 64'd0);
        chk_reg("x0", 5'd0, 64'd0, 1'b0);

        // Disabled ports ignore their address and data
        wr_addr  = {5'd5, 5'd5};
        wr_data  = {64'hBAD, 64'hBAD};
        iss_addr = {5'd5, 5'd5};
        tick();
        idle();
        chk_reg("x5_ignored", 5'd5, 64'h1234, 1'b0);

        // Same-cycle write/read of x4 (busy beforehand)
        set_wr(0, 5'd4, 64'h11);
        set_iss(0, 5'd4);
        tick();
        idle();
        set_wr(0, 5'd4, 64'h77);
        set_rd(0, 5'd4);
        #1;
`ifdef SUPERSCALAR_REGFILE_BYPASS_EN
        chk("x4_fwd_data", rdat(0), 64'h77);
        chk("x4_fwd_busy", {63'd0, rd_busy[0]}, 64'd0);
`else
        chk("x4_fwd_data", rdat(0), 64'h11);
        chk("x4_fwd_busy", {63'd0, rd_busy[0]}, 64'd1);
`endif
        tick();
        idle();
        chk_reg("x4_after", 5'd4, 64'h77, 1'b0);

        // Reset in the middle of writes and issues
        set_iss(0, 5'd20);
        tick();
        idle();
        chk_reg("x20_busy", 5'd20, 64'd0, 1'b1);
        rst_n = 1'b0;
        set_wr(0, 5'd4, 64'h99);
        set_wr(1, 5'd4, 64'h98);
        set_iss(1, 5'd21);
        tick();
        idle();
        chk("rst2_conf", {63'd0, wr_conflict}, 64'd0);
        set_rd(1, 5'd20); set_rd(2, 5'd21); set_rd(3, 5'd5);
        chk_reg("x4_rst", 5'd4, 64'd0, 1'b0);
        chk("rst2_busy", {60'd0, rd_busy}, 64'd0);
        chk("x5_rst", rdat(3), 64'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
